// File: rtl/stage_memory.sv
// Memory pipeline stage: issues word loads/stores on a valid/ready data port,
// passes ALU results to writeback and forwards its registered result upstream.
module stage_memory #(
  parameter int unsigned CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  output logic        stall,
  input  logic [3:0]  in_dest,
  input  logic [31:0] in_val,
  input  logic        in_is_mem,
  input  logic        in_mem_write,
  input  logic [31:0] in_mem_addr,
  input  logic [31:0] in_mem_val,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_val,
  output logic        fwd_valid,
  output logic [3:0]  fwd_addr,
  output logic [31:0] fwd_val,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_HELD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic [31:0] ldbuf_q, ldbuf_d;
  logic        misalign_q, misalign_d;
  logic        aligned;
  logic        done;

  assign aligned    = (CHECK_ALIGN == 0) || (in_mem_addr[1:0] == 2'b00);
  assign dmem_we    = in_mem_write;
  assign dmem_addr  = in_mem_addr;
  assign dmem_wdata = in_mem_val;

  assign wb_addr    = wb_addr_q;
  assign wb_val     = wb_val_q;
  assign fwd_valid  = (wb_addr_q != 4'd0);
  assign fwd_addr   = wb_addr_q;
  assign fwd_val    = wb_val_q;
  assign misalign   = misalign_q;

  always_comb begin
    state_d    = state_q;
    wb_addr_d  = wb_addr_q;
    wb_val_d   = wb_val_q;
    ldbuf_d    = ldbuf_q;
    misalign_d = 1'b0;
    dmem_req   = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Request is gated by rst so nothing leaks onto the port during reset.
        dmem_req = rst & in_is_mem & ~stall_in & aligned;
        if (!stall_in) begin
          if (!in_is_mem) begin
            wb_addr_d = in_dest;
            wb_val_d  = in_val;
          end else begin
            wb_addr_d = '0;
            if (!aligned) begin
              misalign_d = 1'b1;
              done       = 1'b1;
            end else if (dmem_ready) begin
              if (in_mem_write) done = 1'b1;
              else              state_d = LOAD_WAIT;
            end
          end
        end
      end

      LOAD_WAIT: begin
        if (dmem_rvalid) begin
          if (stall_in) begin
            // Writeback is frozen: park the response until it can advance.
            ldbuf_d = dmem_rdata;
            state_d = LOAD_HELD;
          end else begin
            done      = 1'b1;
            wb_addr_d = in_dest;
            wb_val_d  = dmem_rdata;
            state_d   = IDLE;
          end
        end else if (!stall_in) begin
          wb_addr_d = '0;
        end
      end

      LOAD_HELD: begin
        if (!stall_in) begin
          done      = 1'b1;
          wb_addr_d = in_dest;
          wb_val_d  = ldbuf_q;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    stall = stall_in | (in_is_mem & ~done);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wb_addr_q  <= '0;
      wb_val_q   <= '0;
      ldbuf_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_addr_q  <= wb_addr_d;
      wb_val_q   <= wb_val_d;
      ldbuf_q    <= ldbuf_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: ALU pass-through vector table plus hand-written
// load/store/misalign/reset sequences, writeback checked via a scoreboard queue.
module tb_stage_memory;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        stall;
  logic [3:0]  in_dest;
  logic [31:0] in_val;
  logic        in_is_mem;
  logic        in_mem_write;
  logic [31:0] in_mem_addr;
  logic [31:0] in_mem_val;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [3:0]  wb_addr;
  logic [31:0] wb_val;
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_val;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  stage_memory #(.CHECK_ALIGN(1)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .stall(stall),
    .in_dest(in_dest), .in_val(in_val), .in_is_mem(in_is_mem),
    .in_mem_write(in_mem_write), .in_mem_addr(in_mem_addr), .in_mem_val(in_mem_val),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_addr(wb_addr), .wb_val(wb_val), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_val(fwd_val), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] val;
    logic        si;
    logic        exp_stall;
    logic [3:0]  exp_wa;
    logic [31:0] exp_wv;
  } vec_t;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] v;
  } wb_t;

  vec_t vecs[6];
  wb_t  sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wb(input logic [3:0] a, input logic [31:0] v);
    wb_t e;
    e.a = a;
    e.v = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string name);
    wb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got empty scoreboard expected entry", name);
    end else begin
      e = sb_q.pop_front();
      if (wb_addr !== e.a || wb_val !== e.v) begin
        errors++;
        $display("FAIL %s: got wb %0h/%0h expected %0h/%0h", name, wb_addr, wb_val, e.a, e.v);
      end
    end
  endtask

  task automatic idle_inputs();
    stall_in = 1'b0; in_dest = '0; in_val = '0; in_is_mem = 1'b0;
    in_mem_write = 1'b0; in_mem_addr = '0; in_mem_val = '0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{dest: 4'd3,  val: 32'h0000_1234, si: 1'b0, exp_stall: 1'b0, exp_wa: 4'd3,  exp_wv: 32'h0000_1234};
    vecs[1] = '{dest: 4'd7,  val: 32'hFFFF_FFFF, si: 1'b1, exp_stall: 1'b1, exp_wa: 4'd3,  exp_wv: 32'h0000_1234};
    vecs[2] = '{dest: 4'd7,  val: 32'hFFFF_FFFF, si: 1'b0, exp_stall: 1'b0, exp_wa: 4'd7,  exp_wv: 32'hFFFF_FFFF};
    vecs[3] = '{dest: 4'd0,  val: 32'h0000_CAFE, si: 1'b0, exp_stall: 1'b0, exp_wa: 4'd0,  exp_wv: 32'h0000_CAFE};
    vecs[4] = '{dest: 4'd15, val: 32'h0000_0000, si: 1'b0, exp_stall: 1'b0, exp_wa: 4'd15, exp_wv: 32'h0000_0000};
    vecs[5] = '{dest: 4'd1,  val: 32'h8000_0000, si: 1'b0, exp_stall: 1'b0, exp_wa: 4'd1,  exp_wv: 32'h8000_0000};

    rst = 1'b0;
    idle_inputs();
    #3;
    chk("reset_wb_addr", {28'd0, wb_addr}, 32'd0);
    chk("reset_wb_val", wb_val, 32'd0);
    chk("reset_misalign", {31'd0, misalign}, 32'd0);
    chk("reset_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    in_is_mem = 1'b1;
    #1;
    chk("reset_dmem_req", {31'd0, dmem_req}, 32'd0);
    in_is_mem = 1'b0;
    tick();
    rst = 1'b1;

    // ALU pass-through table
    for (int i = 0; i < 6; i++) begin
      in_dest = vecs[i].dest; in_val = vecs[i].val; stall_in = vecs[i].si;
      #1;
      chk($sformatf("alu%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      chk($sformatf("alu%0d_req", i), {31'd0, dmem_req}, 32'd0);
      push_wb(vecs[i].exp_wa, vecs[i].exp_wv);
      tick();
      pop_check($sformatf("alu%0d_wb", i));
      chk($sformatf("alu%0d_fwd_valid", i), {31'd0, fwd_valid}, {31'd0, (vecs[i].exp_wa != 4'd0)});
      chk($sformatf("alu%0d_fwd_addr", i), {28'd0, fwd_addr}, {28'd0, vecs[i].exp_wa});
      chk($sformatf("alu%0d_fwd_val", i), fwd_val, vecs[i].exp_wv);
    end
    stall_in = 1'b0;

    // Load: accepted cycle 0, data in cycle 2
    in_dest = 4'd5; in_is_mem = 1'b1; in_mem_write = 1'b0; in_mem_addr = 32'h100;
    dmem_ready = 1'b1;
    #1;
    chk("ld_c0_req", {31'd0, dmem_req}, 32'd1);
    chk("ld_c0_we", {31'd0, dmem_we}, 32'd0);
    chk("ld_c0_addr", dmem_addr, 32'h100);
    chk("ld_c0_stall", {31'd0, stall}, 32'd1);
    push_wb(4'd0, 32'h8000_0000);
    tick();
    pop_check("ld_c0_wb");
    dmem_ready = 1'b0;
    #1;
    chk("ld_c1_req", {31'd0, dmem_req}, 32'd0);
    chk("ld_c1_stall", {31'd0, stall}, 32'd1);
    push_wb(4'd0, 32'h8000_0000);
    tick();
    pop_check("ld_c1_wb");
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_c2_req", {31'd0, dmem_req}, 32'd0);
    chk("ld_c2_stall", {31'd0, stall}, 32'd0);
    push_wb(4'd5, 32'hDEAD_BEEF);
    tick();
    pop_check("ld_c2_wb");
    dmem_rvalid = 1'b0;

    // Store held off by dmem_ready for two cycles
    in_dest = 4'd6; in_mem_write = 1'b1; in_mem_addr = 32'h20; in_mem_val = 32'hA5A5_A5A5;
    for (int c = 0; c < 3; c++) begin
      dmem_ready = (c == 2);
      #1;
      chk($sformatf("st_c%0d_req", c), {31'd0, dmem_req}, 32'd1);
      chk($sformatf("st_c%0d_we", c), {31'd0, dmem_we}, 32'd1);
      chk($sformatf("st_c%0d_addr", c), dmem_addr, 32'h20);
      chk($sformatf("st_c%0d_wdata", c), dmem_wdata, 32'hA5A5_A5A5);
      chk($sformatf("st_c%0d_stall", c), {31'd0, stall}, {31'd0, (c != 2)});
      push_wb(4'd0, 32'hDEAD_BEEF);
      tick();
      pop_check($sformatf("st_c%0d_wb", c));
    end
    dmem_ready = 1'b0;

    // Load whose data lands while writeback stalls
    in_dest = 4'd9; in_mem_write = 1'b0; in_mem_addr = 32'h40; dmem_ready = 1'b1;
    #1;
    chk("ldh_acc_req", {31'd0, dmem_req}, 32'd1);
    push_wb(4'd0, 32'hDEAD_BEEF);
    tick();
    pop_check("ldh_acc_wb");
    dmem_ready = 1'b0;
    stall_in = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h77;
    #1;
    chk("ldh_s0_stall", {31'd0, stall}, 32'd1);
    chk("ldh_s0_req", {31'd0, dmem_req}, 32'd0);
    push_wb(4'd0, 32'hDEAD_BEEF);
    tick();
    pop_check("ldh_s0_wb");
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #1;
    chk("ldh_s1_stall", {31'd0, stall}, 32'd1);
    push_wb(4'd0, 32'hDEAD_BEEF);
    tick();
    pop_check("ldh_s1_wb");
    stall_in = 1'b0;
    #1;
    chk("ldh_rel_stall", {31'd0, stall}, 32'd0);
    chk("ldh_rel_req", {31'd0, dmem_req}, 32'd0);
    push_wb(4'd9, 32'h77);
    tick();
    pop_check("ldh_rel_wb");

    // Misaligned load is dropped
    in_dest = 4'd4; in_mem_addr = 32'h102;
    #1;
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    push_wb(4'd0, 32'h77);
    tick();
    pop_check("mis_wb");
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    in_is_mem = 1'b0; in_dest = 4'd2; in_val = 32'h55;
    push_wb(4'd2, 32'h55);
    tick();
    pop_check("mis_after_wb");
    chk("mis_pulse_end", {31'd0, misalign}, 32'd0);

    // Reset while a load is outstanding
    in_is_mem = 1'b1; in_dest = 4'd6; in_mem_addr = 32'h200; dmem_ready = 1'b1;
    push_wb(4'd0, 32'h55);
    tick();
    pop_check("rl_acc_wb");
    dmem_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rl_rst_wb_addr", {28'd0, wb_addr}, 32'd0);
    chk("rl_rst_wb_val", wb_val, 32'd0);
    chk("rl_rst_req", {31'd0, dmem_req}, 32'd0);
    #1;
    rst = 1'b1;
    in_is_mem = 1'b0; in_dest = 4'd0; in_val = 32'h11;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h99;
    #1;
    chk("rl_late_stall", {31'd0, stall}, 32'd0);
    chk("rl_late_req", {31'd0, dmem_req}, 32'd0);
    push_wb(4'd0, 32'h11);
    tick();
    pop_check("rl_late_wb");
    in_is_mem = 1'b1; in_dest = 4'd6; in_mem_addr = 32'h300;
    #1;
    chk("rl_idle_req", {31'd0, dmem_req}, 32'd1);
    chk("rl_idle_stall", {31'd0, stall}, 32'd1);
    push_wb(4'd0, 32'h11);
    tick();
    pop_check("rl_idle_wb");
    dmem_rvalid = 1'b0;
    in_is_mem = 1'b0; in_dest = 4'd8; in_val = 32'hABCD;
    #1;
    chk("rl_alu_stall", {31'd0, stall}, 32'd0);
    push_wb(4'd8, 32'hABCD);
    tick();
    pop_check("rl_alu_wb");
    chk("rl_alu_fwd_valid", {31'd0, fwd_valid}, 32'd1);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
